// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Fetch-stage branch predictor: a direction predictor (bimodal or gshare,
//   chosen by PRED_MODE) paired with an N-way set-associative BTB that uses
//   per-set round-robin replacement once a set is full.
//   The lookup of pc is registered, so outputs appear one cycle later. They
//   reflect table contents from before any update applied on that same edge.
//
// Ports
//   clk                 in   clock
//   rst                 in   synchronous reset, active-high
//   update_predictor    in   train the PHT (and shift the GHR in gshare mode)
//   update_btb          in   write the resolved target into the BTB
//   actually_taken      in   resolved branch direction
//   resolved_pc         in   PC of the resolved branch
//   resolved_pc_target  in   resolved target address
//   pc                  in   fetch PC to look up
//   hit                 out  BTB tag match for the previous-cycle pc
//   pred                out  predicted taken for the previous-cycle pc
//   branch_target       out  target of the hitting way, 0 on a miss

module branch_predict_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 2,
    parameter int PHT_ENTRIES   = 256,
    parameter int HIST_WIDTH    = 8,
    parameter int PRED_MODE     = 1,
    parameter int BTB_SETS      = 64,
    parameter int BTB_WAYS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update_predictor,
    input  logic                  update_btb,
    input  logic                  actually_taken,
    input  logic [DATA_WIDTH-1:0] resolved_pc,
    input  logic [DATA_WIDTH-1:0] resolved_pc_target,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  hit,
    output logic                  pred,
    output logic [DATA_WIDTH-1:0] branch_target
);

    localparam int PHT_IDX = $clog2(PHT_ENTRIES);
    localparam int SET_IDX = $clog2(BTB_SETS);
    localparam int WAY_IDX = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam int TAG_W   = DATA_WIDTH - SET_IDX - 2;

    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;
    // Weakly-not-taken: 2^(CW-1)-1
    localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = CTR_MAX >> 1;
    localparam logic [WAY_IDX-1:0]       WAY_LAST = WAY_IDX'(BTB_WAYS - 1);

    function automatic logic [COUNTER_WIDTH-1:0] ctr_train(
        input logic [COUNTER_WIDTH-1:0] c,
        input logic                     taken
    );
        if (taken)
            return (c == CTR_MAX) ? c : c + COUNTER_WIDTH'(1);
        else
            return (c == '0) ? c : c - COUNTER_WIDTH'(1);
    endfunction

    function automatic logic [PHT_IDX-1:0] pht_index(
        input logic [DATA_WIDTH-1:0] addr,
        input logic [HIST_WIDTH-1:0] hist
    );
        logic [PHT_IDX-1:0] idx;
        idx = addr[PHT_IDX+1:2];
        if (PRED_MODE != 0)
            idx = idx ^ PHT_IDX'(hist);
        return idx;
    endfunction

    function automatic logic [WAY_IDX-1:0] ptr_next(input logic [WAY_IDX-1:0] p);
        return (p == WAY_LAST) ? '0 : p + WAY_IDX'(1);
    endfunction

    logic [COUNTER_WIDTH-1:0] pht        [PHT_ENTRIES];
    logic [HIST_WIDTH-1:0]    ghr;
    logic                     btb_valid  [BTB_SETS][BTB_WAYS];
    logic [TAG_W-1:0]         btb_tag    [BTB_SETS][BTB_WAYS];
    logic [DATA_WIDTH-1:0]    btb_target [BTB_SETS][BTB_WAYS];
    logic [WAY_IDX-1:0]       rr_ptr     [BTB_SETS];

    // Address bits [1:0] never take part in indexing or tagging.
    logic unused_low_bits;
    assign unused_low_bits = ^{pc[1:0], resolved_pc[1:0]};

    // ---- lookup stage (combinational, registered below) ----
    logic [PHT_IDX-1:0]    lk_idx;
    logic [SET_IDX-1:0]    lk_set;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic [DATA_WIDTH-1:0] lk_target;

    always_comb begin
        lk_idx    = pht_index(pc, ghr);
        lk_set    = pc[SET_IDX+1:2];
        lk_tag    = pc[DATA_WIDTH-1:SET_IDX+2];
        lk_hit    = 1'b0;
        lk_target = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (btb_valid[lk_set][w] && btb_tag[lk_set][w] == lk_tag) begin
                lk_hit    = 1'b1;
                lk_target = btb_target[lk_set][w];
            end
        end
    end

    // ---- update stage: way selection for the BTB write ----
    logic [PHT_IDX-1:0] up_idx;
    logic [SET_IDX-1:0] up_set;
    logic [TAG_W-1:0]   up_tag;
    logic               same_found;
    logic [WAY_IDX-1:0] same_way;
    logic               free_found;
    logic [WAY_IDX-1:0] free_way;
    logic [WAY_IDX-1:0] wr_way;
    logic               wr_advance;

    always_comb begin
        up_idx     = pht_index(resolved_pc, ghr);
        up_set     = resolved_pc[SET_IDX+1:2];
        up_tag     = resolved_pc[DATA_WIDTH-1:SET_IDX+2];
        same_found = 1'b0;
        same_way   = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (!same_found && btb_valid[up_set][w] && btb_tag[up_set][w] == up_tag) begin
                same_found = 1'b1;
                same_way   = WAY_IDX'(w);
            end
            // Ascending scan with a found-guard picks the lowest invalid way.
            if (!free_found && !btb_valid[up_set][w]) begin
                free_found = 1'b1;
                free_way   = WAY_IDX'(w);
            end
        end
        // An existing tag always wins so a set never holds duplicate tags.
        wr_advance = !same_found && !free_found;
        if (same_found)
            wr_way = same_way;
        else if (free_found)
            wr_way = free_way;
        else
            wr_way = rr_ptr[up_set];
    end

    // ---- registered outputs and control state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hit           <= 1'b0;
            pred          <= 1'b0;
            branch_target <= '0;
            ghr           <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++)
                pht[i] <= CTR_INIT;
            for (int s = 0; s < BTB_SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < BTB_WAYS; w++)
                    btb_valid[s][w] <= 1'b0;
            end
        end else begin
            hit           <= lk_hit;
            pred          <= pht[lk_idx][COUNTER_WIDTH-1];
            branch_target <= lk_target;
            if (update_predictor) begin
                pht[up_idx] <= ctr_train(pht[up_idx], actually_taken);
                // History is committed from resolved branches only.
                if (PRED_MODE != 0)
                    ghr <= (ghr << 1) | HIST_WIDTH'(actually_taken);
            end
            if (update_btb) begin
                btb_valid[up_set][wr_way] <= 1'b1;
                if (wr_advance)
                    rr_ptr[up_set] <= ptr_next(rr_ptr[up_set]);
            end
        end
    end

    // Tag/target storage is gated by btb_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (update_btb) begin
            btb_tag[up_set][wr_way]    <= up_tag;
            btb_target[up_set][wr_way] <= resolved_pc_target;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: a gshare instance and a bimodal instance
// share one stimulus stream. Directed vectors cover reset, saturation,
// gshare aliasing and BTB fill/replace/overwrite/conflict; a random phase
// follows, checked cycle by cycle against a behavioural model.

module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, ub, tk;
    logic [31:0] rpc, rtgt, pc;
    logic        hit_g, pred_g, hit_b, pred_b;
    logic [31:0] tgt_g, tgt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.PRED_MODE(1)) dut_g (
        .clk(clk), .rst(rst), .update_predictor(up), .update_btb(ub),
        .actually_taken(tk), .resolved_pc(rpc), .resolved_pc_target(rtgt),
        .pc(pc), .hit(hit_g), .pred(pred_g), .branch_target(tgt_g)
    );

    branch_predict_unit #(.PRED_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .update_predictor(up), .update_btb(ub),
        .actually_taken(tk), .resolved_pc(rpc), .resolved_pc_target(rtgt),
        .pc(pc), .hit(hit_b), .pred(pred_b), .branch_target(tgt_b)
    );

    // ---------------- behavioural model ----------------
    int          m_pht [2][256];   // [0]=bimodal, [1]=gshare
    int          m_ghr;            // gshare history; bimodal uses none
    bit          m_v   [64][4];
    int unsigned m_tag [64][4];
    logic [31:0] m_tt  [64][4];
    int          m_ptr [64];

    function automatic int pidx(input int mode, input logic [31:0] a);
        int unsigned base;
        base = (a >> 2) % 256;
        return (mode == 1) ? int'((base ^ m_ghr) % 256) : int'(base);
    endfunction

    task automatic model_reset();
        m_ghr = 0;
        for (int i = 0; i < 256; i++) begin m_pht[0][i] = 1; m_pht[1][i] = 1; end
        for (int s = 0; s < 64; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 4; w++) m_v[s][w] = 0;
        end
    endtask

    task automatic model_lookup(input logic [31:0] a, output bit h,
                                output logic [31:0] t, output bit pg, output bit pb);
        int s;
        int unsigned tg;
        s  = int'((a >> 2) % 64);
        tg = a >> 8;
        h  = 0;
        t  = 0;
        for (int w = 0; w < 4; w++)
            if (m_v[s][w] && m_tag[s][w] == tg) begin h = 1; t = m_tt[s][w]; end
        pg = (m_pht[1][pidx(1, a)] >= 2);
        pb = (m_pht[0][pidx(0, a)] >= 2);
    endtask

    task automatic model_train(input logic [31:0] a, input bit taken);
        for (int m = 0; m < 2; m++) begin
            int i;
            i = pidx(m, a);
            if (taken) m_pht[m][i] = (m_pht[m][i] < 3) ? m_pht[m][i] + 1 : 3;
            else       m_pht[m][i] = (m_pht[m][i] > 0) ? m_pht[m][i] - 1 : 0;
        end
        m_ghr = ((m_ghr << 1) | int'(taken)) % 256;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] t);
        int s, found, free;
        int unsigned tg;
        s = int'((a >> 2) % 64);
        tg = a >> 8;
        found = -1;
        free  = -1;
        for (int w = 0; w < 4; w++) begin
            if (m_v[s][w] && m_tag[s][w] == tg) found = w;
            if (!m_v[s][w] && free < 0) free = w;
        end
        if (found >= 0) begin
            m_tt[s][found] = t;
        end else if (free >= 0) begin
            m_v[s][free] = 1; m_tag[s][free] = tg; m_tt[s][free] = t;
        end else begin
            m_tag[s][m_ptr[s]] = tg; m_tt[s][m_ptr[s]] = t;
            m_ptr[s] = (m_ptr[s] + 1) % 4;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: predict from pre-edge model state, then apply the edge's
    // updates to the model, then compare every output of both instances.
    task automatic step();
        bit          eh, epg, epb;
        logic [31:0] et;
        if (rst) begin eh = 0; et = 0; epg = 0; epb = 0; end
        else model_lookup(pc, eh, et, epg, epb);
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            if (up) model_train(rpc, tk);
            if (ub) model_write(rpc, rtgt);
        end
        chk("mdl_hit_g",  32'(hit_g),  32'(eh));
        chk("mdl_tgt_g",  tgt_g,       et);
        chk("mdl_pred_g", 32'(pred_g), 32'(epg));
        chk("mdl_hit_b",  32'(hit_b),  32'(eh));
        chk("mdl_tgt_b",  tgt_b,       et);
        chk("mdl_pred_b", 32'(pred_b), 32'(epb));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst, up, ub, tk;
        logic [31:0] rpc, rtgt, pc;
        bit          hit;
        logic [31:0] tgt;
        bit          pb, cpg, pg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit u_p, input bit u_b, input bit t,
                       input logic [31:0] a, input logic [31:0] tg, input logic [31:0] p,
                       input bit h, input logic [31:0] et, input bit pb,
                       input bit cpg, input bit pg);
        vec_t v;
        v.rst = r; v.up = u_p; v.ub = u_b; v.tk = t; v.rpc = a; v.rtgt = tg; v.pc = p;
        v.hit = h; v.tgt = et; v.pb = pb; v.cpg = cpg; v.pg = pg;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    localparam logic [31:0] T1 = 32'h0000_1111, T2 = 32'h0000_2222, T3 = 32'h0000_3333;
    localparam logic [31:0] T4 = 32'h0000_4444, T5 = 32'h0000_5555, T6 = 32'h0000_6666;
    localparam logic [31:0] T7 = 32'h0000_7777, T8 = 32'h0000_8888;

    initial begin
        rst = 1; up = 0; ub = 0; tk = 0; rpc = 0; rtgt = 0; pc = 32'h100;

        //   rst up ub tk rpc      rtgt   pc        hit tgt    pb cpg pg
        // reset, held two cycles, then lookup 0x100
        add(1, 0, 0, 0, 0,        0,     32'h100,  0, 0,     0, 1, 0);
        add(1, 0, 0, 0, 0,        0,     32'h100,  0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h100,  0, 0,     0, 1, 0);
        // bimodal saturation on 0x40: taken x3 (1->2->3->3)
        add(0, 1, 0, 1, 32'h40,   0,     32'h40,   0, 0,     0, 0, 0);
        add(0, 1, 0, 1, 32'h40,   0,     32'h40,   0, 0,     1, 0, 0);
        add(0, 1, 0, 1, 32'h40,   0,     32'h40,   0, 0,     1, 0, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     1, 0, 0);
        // one not-taken -> 2, still predicts taken
        add(0, 1, 0, 0, 32'h40,   0,     32'h40,   0, 0,     1, 0, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     1, 0, 0);
        // two more not-taken -> 0
        add(0, 1, 0, 0, 32'h40,   0,     32'h40,   0, 0,     1, 0, 0);
        add(0, 1, 0, 0, 32'h40,   0,     32'h40,   0, 0,     0, 0, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     0, 0, 0);
        // five more not-taken: stays at 0
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 32'h40, 0,   32'h40,   0, 0,     0, 0, 0);
        // one taken -> 1 (a wrapped counter would read back as taken)
        add(0, 1, 0, 1, 32'h40,   0,     32'h40,   0, 0,     0, 0, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     0, 0, 0);
        add(0, 1, 0, 1, 32'h40,   0,     32'h40,   0, 0,     0, 0, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     1, 0, 0);
        // fresh reset, then gshare aliasing on 0x80
        add(1, 0, 0, 0, 0,        0,     32'h0,    0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h0,    0, 0,     0, 1, 0);
        add(0, 1, 0, 1, 32'h80,   0,     32'h80,   0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h80,   0, 0,     1, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h84,   0, 0,     0, 1, 1);
        // BTB fill and round-robin replacement in set 0
        add(0, 0, 1, 0, 32'h1000, T1,    32'h1000, 0, 0,     0, 1, 0);
        add(0, 0, 1, 0, 32'h2000, T2,    32'h1000, 1, T1,    0, 1, 0);
        add(0, 0, 1, 0, 32'h3000, T3,    32'h2000, 1, T2,    0, 1, 0);
        add(0, 0, 1, 0, 32'h4000, T4,    32'h3000, 1, T3,    0, 1, 0);
        add(0, 0, 1, 0, 32'h5000, T5,    32'h4000, 1, T4,    0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h1000, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h5000, 1, T5,    0, 1, 0);
        add(0, 0, 1, 0, 32'h6000, T6,    32'h2000, 1, T2,    0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h2000, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h6000, 1, T6,    0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h3000, 1, T3,    0, 1, 0);
        // same-tag overwrite in set 1
        add(0, 0, 1, 0, 32'h1004, 32'hA0, 32'h1004, 0, 0,    0, 1, 0);
        add(0, 0, 1, 0, 32'h1004, 32'hB0, 32'h1004, 1, 32'hA0, 0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h1004, 1, 32'hB0, 0, 1, 0);
        add(0, 0, 1, 0, 32'h2004, T2,    32'h1004, 1, 32'hB0, 0, 1, 0);
        add(0, 0, 1, 0, 32'h3004, T3,    32'h1004, 1, 32'hB0, 0, 1, 0);
        add(0, 0, 1, 0, 32'h4004, T4,    32'h1004, 1, 32'hB0, 0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h2004, 1, T2,    0, 1, 0);
        // same-cycle write/lookup conflict in set 2, low pc bits ignored
        add(0, 0, 1, 0, 32'h2008, T7,    32'h2008, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h2008, 1, T7,    0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h200B, 1, T7,    0, 1, 0);
        // reset with both updates active wipes everything
        add(1, 1, 1, 1, 32'h3008, T8,    32'h2008, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h2008, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h3008, 0, 0,     0, 1, 0);
        add(0, 0, 0, 0, 0,        0,     32'h40,   0, 0,     0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; up = vecs[i].up; ub = vecs[i].ub; tk = vecs[i].tk;
            rpc = vecs[i].rpc; rtgt = vecs[i].rtgt; pc = vecs[i].pc;
            step();
            chk($sformatf("vec%0d_hit_g", i),  32'(hit_g),  32'(vecs[i].hit));
            chk($sformatf("vec%0d_hit_b", i),  32'(hit_b),  32'(vecs[i].hit));
            chk($sformatf("vec%0d_tgt_g", i),  tgt_g,       vecs[i].tgt);
            chk($sformatf("vec%0d_pred_b", i), 32'(pred_b), 32'(vecs[i].pb));
            if (vecs[i].cpg)
                chk($sformatf("vec%0d_pred_g", i), 32'(pred_g), 32'(vecs[i].pg));
        end

        // ---------------- random phase ----------------
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            up   = 1'($urandom_range(0, 1));
            ub   = ($urandom_range(0, 2) == 0);
            tk   = 1'($urandom_range(0, 1));
            rpc  = rand_pc();
            rtgt = $urandom;
            pc   = ($urandom_range(0, 7) == 0) ? rpc : rand_pc();
            step();
        end

        rst = 0; up = 0; ub = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
